// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller driving a synchronous single-port SRAM with configurable latency.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN (otherwise addresses are force-aligned).
module lsu_mem_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int WR_LATENCY = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              REQ_VALID,
  input  logic              REQ_WE,
  input  logic [2:0]        REQ_FUNCT3,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              MEM_CSB,
  output logic              MEM_WE,
  output logic [ADDR_W-3:0] MEM_ADDR,
  output logic [3:0]        MEM_WMASK,
  output logic [31:0]       MEM_WDATA,
  input  logic [31:0]       MEM_RDATA,
  output logic              STALL,
  output logic              RESP_VALID,
  output logic [31:0]       RESP_RDATA,
  output logic              MISALIGN
);

  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [2:0]         f3_q;
  logic               we_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               accept;
  logic [3:0]         lane_mask;
  logic [31:0]        lane_wdata;
  logic [31:0]        load_val;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   align_addr = a;
      2'b01:   align_addr = {a[ADDR_W-1:1], 1'b0};
      default: align_addr = {a[ADDR_W-1:2], 2'b00};
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned, trap_fire, trap_blk_q, misalign_q;

  assign misaligned = ((REQ_FUNCT3[1:0] == 2'b01) && REQ_ADDR[0]) ||
                      (REQ_FUNCT3[1] && (REQ_ADDR[1:0] != 2'b00));
  assign trap_fire  = (state_q == IDLE) && REQ_VALID && EN && !RST && misaligned && !trap_blk_q;
  assign accept     = (state_q == IDLE) && REQ_VALID && EN && !RST && !misaligned;
  assign MISALIGN   = misalign_q;

  // A held misaligned request traps once; re-arm only after REQ_VALID drops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      trap_blk_q <= 1'b0;
      misalign_q <= 1'b0;
    end else if (EN) begin
      misalign_q <= trap_fire;
      if (!REQ_VALID)     trap_blk_q <= 1'b0;
      else if (trap_fire) trap_blk_q <= 1'b1;
    end
  end
`else
  assign accept   = (state_q == IDLE) && REQ_VALID && EN && !RST;
  assign MISALIGN = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (EN) begin
      case (state_q)
        IDLE:    if (accept) state_d = ACCESS;
        ACCESS:  state_d = WAIT;
        WAIT:    if (cnt_q == '0) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (EN) begin
      if (accept) begin
        addr_q  <= align_addr(REQ_ADDR, REQ_FUNCT3);
        f3_q    <= REQ_FUNCT3;
        we_q    <= REQ_WE;
        wdata_q <= REQ_WDATA;
      end
      if (state_q == ACCESS) cnt_q <= we_q ? WR_CNT : RD_CNT;
      if (state_q == WAIT) begin
        if (cnt_q == '0) rdata_q <= we_q ? 32'd0 : load_val;
        else             cnt_q   <= cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    ld_byte = MEM_RDATA[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
    case (f3_q[1:0])
      2'b00:   load_val = f3_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_val = f3_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_val = MEM_RDATA;
    endcase
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        lane_mask  = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask  = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  // SRAM pins are only non-idle during the single ACCESS cycle.
  assign MEM_CSB    = (state_q != ACCESS);
  assign MEM_WE     = (state_q == ACCESS) && we_q;
  assign MEM_ADDR   = (state_q == ACCESS) ? addr_q[ADDR_W-1:2] : '0;
  assign MEM_WMASK  = MEM_WE ? lane_mask : 4'b0000;
  assign MEM_WDATA  = MEM_WE ? lane_wdata : 32'd0;
  assign STALL      = accept || (state_q == ACCESS) || (state_q == WAIT);
  assign RESP_VALID = (state_q == DONE);
  assign RESP_RDATA = rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: two instances (read latency 1 and 4) each backed by a small SRAM model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, rv1, rv4, req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata;

  logic        csb1, mwe1, stall1, resp1, mis1;
  logic [29:0] maddr1;
  logic [3:0]  mask1;
  logic [31:0] mwd1, mrd1, rdata1;
  logic        csb4, mwe4, stall4, resp4, mis4;
  logic [29:0] maddr4;
  logic [3:0]  mask4;
  logic [31:0] mwd4, mrd4, rdata4;

  bit [31:0] mem1 [256];
  bit [31:0] mem4 [256];

  int n_pass = 0;
  int n_total = 0;
  bit sel;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(32), .RD_LATENCY(1), .WR_LATENCY(1)) u1 (
    .CLK(clk), .RST(rst), .EN(en), .REQ_VALID(rv1), .REQ_WE(req_we), .REQ_FUNCT3(req_f3),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .MEM_CSB(csb1), .MEM_WE(mwe1), .MEM_ADDR(maddr1),
    .MEM_WMASK(mask1), .MEM_WDATA(mwd1), .MEM_RDATA(mrd1), .STALL(stall1), .RESP_VALID(resp1),
    .RESP_RDATA(rdata1), .MISALIGN(mis1));

  lsu_mem_ctrl #(.ADDR_W(32), .RD_LATENCY(4), .WR_LATENCY(2)) u4 (
    .CLK(clk), .RST(rst), .EN(en), .REQ_VALID(rv4), .REQ_WE(req_we), .REQ_FUNCT3(req_f3),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .MEM_CSB(csb4), .MEM_WE(mwe4), .MEM_ADDR(maddr4),
    .MEM_WMASK(mask4), .MEM_WDATA(mwd4), .MEM_RDATA(mrd4), .STALL(stall4), .RESP_VALID(resp4),
    .RESP_RDATA(rdata4), .MISALIGN(mis4));

  // Synchronous SRAM models: read data appears after the CSB-low edge and holds.
  always @(posedge clk) begin
    if (!csb1) begin
      if (mwe1) begin
        for (int b = 0; b < 4; b++) if (mask1[b]) mem1[maddr1[7:0]][b*8 +: 8] <= mwd1[b*8 +: 8];
      end else mrd1 <= mem1[maddr1[7:0]];
    end
    if (!csb4) begin
      if (mwe4) begin
        for (int b = 0; b < 4; b++) if (mask4[b]) mem4[maddr4[7:0]][b*8 +: 8] <= mwd4[b*8 +: 8];
      end else mrd4 <= mem4[maddr4[7:0]];
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  emask;
    logic [31:0] ewd;
    logic [29:0] emaddr;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // One complete access on the selected instance; drop>=0 pulls EN low for two edges after that sample.
  task automatic run_access(input bit s4, input logic we_i, input logic [2:0] f3_i,
                            input logic [31:0] a_i, input logic [31:0] wd_i, input int drop,
                            output logic [3:0] o_mask, output logic [31:0] o_wd,
                            output logic [29:0] o_maddr, output logic o_we,
                            output logic [31:0] o_rd, output int o_stall, output int o_done,
                            output int o_csb, output int o_mis);
    @(negedge clk);
    sel = s4;
    req_we = we_i; req_f3 = f3_i; req_addr = a_i; req_wdata = wd_i;
    if (s4) rv4 = 1'b1; else rv1 = 1'b1;
    o_mask = '0; o_wd = '0; o_maddr = '0; o_we = 1'b0; o_rd = '0;
    o_stall = 0; o_done = -1; o_csb = 0; o_mis = 0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (sel ? stall4 : stall1) o_stall++;
      if (sel ? mis4 : mis1) o_mis++;
      if (!(sel ? csb4 : csb1)) begin
        o_csb++;
        o_mask  = sel ? mask4 : mask1;
        o_wd    = sel ? mwd4 : mwd1;
        o_maddr = sel ? maddr4 : maddr1;
        o_we    = sel ? mwe4 : mwe1;
      end
      if (sel ? resp4 : resp1) begin
        o_done = k;
        o_rd   = sel ? rdata4 : rdata1;
        break;
      end
      if (k == drop) en = 1'b0;
      if (k == drop + 2) en = 1'b1;
      @(negedge clk);
    end
    rv1 = 1'b0; rv4 = 1'b0; en = 1'b1;
  endtask

  logic [3:0]  g_mask;
  logic [31:0] g_wd, g_rd;
  logic [29:0] g_maddr;
  logic        g_we;
  int          g_stall, g_done, g_csb, g_mis, cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"sw_beef",  1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 30'h4, 32'h0};
    vecs[1]  = '{"lw_beef",  1'b0, 3'd2, 32'h10, 32'h0,        4'b0000, 32'h0,        30'h4, 32'hDEADBEEF};
    vecs[2]  = '{"sw_pat",   1'b1, 3'd2, 32'h00, 32'h80FF7F01, 4'b1111, 32'h80FF7F01, 30'h0, 32'h0};
    vecs[3]  = '{"lb_1",     1'b0, 3'd0, 32'h01, 32'h0,        4'b0000, 32'h0,        30'h0, 32'h0000007F};
    vecs[4]  = '{"lb_2",     1'b0, 3'd0, 32'h02, 32'h0,        4'b0000, 32'h0,        30'h0, 32'hFFFFFFFF};
    vecs[5]  = '{"lbu_3",    1'b0, 3'd4, 32'h03, 32'h0,        4'b0000, 32'h0,        30'h0, 32'h00000080};
    vecs[6]  = '{"lh_2",     1'b0, 3'd1, 32'h02, 32'h0,        4'b0000, 32'h0,        30'h0, 32'hFFFF80FF};
    vecs[7]  = '{"lhu_2",    1'b0, 3'd5, 32'h02, 32'h0,        4'b0000, 32'h0,        30'h0, 32'h000080FF};
    vecs[8]  = '{"lh_0",     1'b0, 3'd1, 32'h00, 32'h0,        4'b0000, 32'h0,        30'h0, 32'h00007F01};
    vecs[9]  = '{"sb_23",    1'b1, 3'd0, 32'h23, 32'h123456AB, 4'b1000, 32'hABABABAB, 30'h8, 32'h0};
    vecs[10] = '{"sh_22",    1'b1, 3'd1, 32'h22, 32'hFFFF1234, 4'b1100, 32'h12341234, 30'h8, 32'h0};
    vecs[11] = '{"lw_20",    1'b0, 3'd2, 32'h20, 32'h0,        4'b0000, 32'h0,        30'h8, 32'h12340000};
    vecs[12] = '{"sw_f3_3",  1'b1, 3'd3, 32'h14, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 30'h5, 32'h0};
    vecs[13] = '{"sb_f3_4",  1'b1, 3'd4, 32'h15, 32'h00000055, 4'b0010, 32'h55555555, 30'h5, 32'h0};
    vecs[14] = '{"lhu_16",   1'b0, 3'd5, 32'h16, 32'h0,        4'b0000, 32'h0,        30'h5, 32'h0000CAFE};
    vecs[15] = '{"lbu_15",   1'b0, 3'd4, 32'h15, 32'h0,        4'b0000, 32'h0,        30'h5, 32'h00000055};
    vecs[16] = '{"lb_14",    1'b0, 3'd0, 32'h14, 32'h0,        4'b0000, 32'h0,        30'h5, 32'h0000000D};

    rst = 1'b1; en = 1'b1; rv1 = 1'b0; rv4 = 1'b0; sel = 1'b0;
    req_we = 1'b0; req_f3 = 3'd0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, stall1}, 32'd0);
    chk("rst_csb",   {31'd0, csb1},   32'd1);
    chk("rst_we",    {31'd0, mwe1},   32'd0);
    chk("rst_resp",  {31'd0, resp1},  32'd0);
    chk("rst_rdata", rdata1,          32'd0);
    chk("rst_mis",   {31'd0, mis1},   32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_access(1'b0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, -1,
                 g_mask, g_wd, g_maddr, g_we, g_rd, g_stall, g_done, g_csb, g_mis);
      chk($sformatf("%s_done", vecs[i].name), g_done, 3);
      chk($sformatf("%s_stall", vecs[i].name), g_stall, 3);
      chk($sformatf("%s_csb", vecs[i].name), g_csb, 1);
      chk($sformatf("%s_maddr", vecs[i].name), {2'b00, g_maddr}, {2'b00, vecs[i].emaddr});
      chk($sformatf("%s_we", vecs[i].name), {31'd0, g_we}, {31'd0, vecs[i].we});
      if (vecs[i].we) begin
        chk($sformatf("%s_mask", vecs[i].name), {28'd0, g_mask}, {28'd0, vecs[i].emask});
        chk($sformatf("%s_wdata", vecs[i].name), g_wd, vecs[i].ewd);
      end
      chk($sformatf("%s_rdata", vecs[i].name), g_rd, vecs[i].erd);
    end

    // Latency-4 read / latency-2 write instance, including an EN freeze mid-WAIT.
    run_access(1'b1, 1'b1, 3'd2, 32'h40, 32'h0BADF00D, -1,
               g_mask, g_wd, g_maddr, g_we, g_rd, g_stall, g_done, g_csb, g_mis);
    chk("l4_sw_done", g_done, 4);
    chk("l4_sw_stall", g_stall, 4);
    run_access(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, -1,
               g_mask, g_wd, g_maddr, g_we, g_rd, g_stall, g_done, g_csb, g_mis);
    chk("l4_lw_done", g_done, 6);
    chk("l4_lw_stall", g_stall, 6);
    chk("l4_lw_rdata", g_rd, 32'h0BADF00D);
    run_access(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 3,
               g_mask, g_wd, g_maddr, g_we, g_rd, g_stall, g_done, g_csb, g_mis);
    chk("l4_en_done", g_done, 8);
    chk("l4_en_stall", g_stall, 8);
    chk("l4_en_csb", g_csb, 1);
    chk("l4_en_rdata", g_rd, 32'h0BADF00D);

`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    sel = 1'b0; req_we = 1'b0; req_f3 = 3'd2; req_addr = 32'h102; rv1 = 1'b1;
    cnt = 0;
    #1;
    chk("trap_c0_stall", {31'd0, stall1}, 32'd0);
    chk("trap_c0_csb",   {31'd0, csb1},   32'd1);
    chk("trap_c0_mis",   {31'd0, mis1},   32'd0);
    @(negedge clk); #1;
    chk("trap_c1_mis",   {31'd0, mis1},   32'd1);
    chk("trap_c1_stall", {31'd0, stall1}, 32'd0);
    chk("trap_c1_csb",   {31'd0, csb1},   32'd1);
    @(negedge clk); #1;
    chk("trap_c2_mis",   {31'd0, mis1},   32'd0);
    chk("trap_c2_csb",   {31'd0, csb1},   32'd1);
    rv1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (resp1 || !csb1) cnt++;
    end
    chk("trap_no_access", cnt, 0);
`else
    run_access(1'b0, 1'b1, 3'd2, 32'h100, 32'h11223344, -1,
               g_mask, g_wd, g_maddr, g_we, g_rd, g_stall, g_done, g_csb, g_mis);
    chk("sw_100_maddr", {2'b00, g_maddr}, 32'h40);
    run_access(1'b0, 1'b0, 3'd2, 32'h102, 32'h0, -1,
               g_mask, g_wd, g_maddr, g_we, g_rd, g_stall, g_done, g_csb, g_mis);
    chk("mis_lw_maddr", {2'b00, g_maddr}, 32'h40);
    chk("mis_lw_done", g_done, 3);
    chk("mis_lw_rdata", g_rd, 32'h11223344);
    chk("mis_lw_pulse", g_mis, 0);
    run_access(1'b0, 1'b0, 3'd1, 32'h23, 32'h0, -1,
               g_mask, g_wd, g_maddr, g_we, g_rd, g_stall, g_done, g_csb, g_mis);
    chk("mis_lh_rdata", g_rd, 32'h00001234);
`endif

    // Reset in the middle of a WAIT on the latency-4 instance.
    @(negedge clk);
    sel = 1'b1; req_we = 1'b0; req_f3 = 3'd2; req_addr = 32'h40; rv4 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_stall", {31'd0, stall4}, 32'd1);
    rst = 1'b1; rv4 = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, stall4}, 32'd0);
    chk("mid_rst_csb",   {31'd0, csb4},   32'd1);
    chk("mid_rst_resp",  {31'd0, resp4},  32'd0);
    chk("mid_rst_rdata", rdata4,          32'd0);
    chk("mid_rst_maddr", {2'b00, maddr4}, 32'd0);
    chk("mid_rst_mask",  {28'd0, mask4},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (resp4) cnt++;
    end
    chk("post_rst_no_resp", cnt, 0);
    run_access(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, -1,
               g_mask, g_wd, g_maddr, g_we, g_rd, g_stall, g_done, g_csb, g_mis);
    chk("post_rst_done", g_done, 6);
    chk("post_rst_rdata", g_rd, 32'h0BADF00D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
